// File: rtl/sseg_pkg.sv
// Shared types, glyph table and anode patterns for the RAM 7-seg scanner.
// Optional leading-zero blanking is enabled by defining BLANK_LEAD_EN.
package sseg_pkg;

  typedef enum logic [1:0] {
    S_ADDR,
    S_CAP,
    S_CONV,
    S_SHOW
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Indexed by digit select; index 3 is the leftmost digit.
  localparam logic [3:0] DIGIT_AN [4] = '{
    4'b1110,
    4'b1101,
    4'b1011,
    4'b0111
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    logic [6:0] g;
    g = 7'h7F;
    case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/ram_sseg_scanner_if.sv
// Read port of the 16x8 result RAM as seen by the display scanner.
// The scanner is master (drives the address), the RAM is slave.
interface ram_sseg_scanner_if;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  modport master (
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/ram_sseg_scanner_bin2bcd.sv
// Sequential 8-bit double-dabble: load on start, 8 shift cycles.
// bcd is the post-shift value and is valid in the cycle done is high.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  logic [11:0] bcd_q;
  logic [7:0]  bin_q;
  logic [2:0]  cnt_q;
  logic        act_q;
  logic [11:0] adj;
  logic [11:0] bcd_nxt;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_nxt = (adj << 1) | 12'(bin_q[7]);
  end

  assign done = act_q && (cnt_q == 3'd7);
  assign bcd  = bcd_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else if (start) begin
      bcd_q <= '0;
      bin_q <= bin;
      cnt_q <= '0;
      act_q <= 1'b1;
    end else if (act_q) begin
      bcd_q <= bcd_nxt;
      bin_q <= bin_q << 1;
      cnt_q <= cnt_q + 3'd1;
      if (cnt_q == 3'd7)
        act_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_sseg_scanner.sv
// Walks the result RAM and shows addr (hex) + value (decimal) on 4-digit 7-seg.
// Define BLANK_LEAD_EN to blank leading zeros of the decimal value.
module ram_sseg_scanner
  import sseg_pkg::*;
#(
  parameter int STEP_BITS    = 26,
  parameter int REFRESH_BITS = 17
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  ram_sseg_scanner_if.master         ram,
  output logic [3:0]                 an,
  output logic [7:0]                 seg,
  output logic                       busy
);

  localparam logic [STEP_BITS-1:0]    STEP_ONE = 1;
  localparam logic [REFRESH_BITS-1:0] REF_ONE  = 1;

  state_t                  state_q, state_d;
  logic                    boot_q;
  logic [3:0]              addr_q;
  logic [STEP_BITS-1:0]    step_q;
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [3:0]              h_q, t_q, o_q;
  logic                    conv_start, conv_done;
  logic [11:0]             conv_bcd;
  logic                    adv;
  logic [1:0]              sel;
  logic                    blank_h, blank_t;
  logic [3:0]              an_d;
  logic [7:0]              seg_d;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (ram.rd_data),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign ram.rd_addr = addr_q;
  assign busy        = (state_q != S_SHOW);
  assign adv         = (state_q == S_SHOW) && en && !boot_q;
  assign sel         = refresh_q[REFRESH_BITS-1 -: 2];

  // Reset parks in S_SHOW with boot_q set so busy stays low until the first clock.
  always_comb begin
    state_d    = state_q;
    conv_start = 1'b0;
    unique case (state_q)
      S_ADDR: state_d = S_CAP;
      S_CAP: begin
        conv_start = 1'b1;
        state_d    = S_CONV;
      end
      S_CONV: if (conv_done) state_d = S_SHOW;
      S_SHOW: if (boot_q || (adv && &step_q)) state_d = S_ADDR;
      default: state_d = S_ADDR;
    endcase
  end

`ifdef BLANK_LEAD_EN
  assign blank_h = (h_q == 4'd0);
  assign blank_t = blank_h && (t_q == 4'd0);
`else
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif

  always_comb begin
    an_d  = DIGIT_AN[sel];
    seg_d = SEG_BLANK;
    unique case (1'b1)
      sel == 2'd3: seg_d = {1'b0, hex2seg(addr_q)};
      sel == 2'd2: seg_d = blank_h ? SEG_BLANK : {1'b1, hex2seg(h_q)};
      sel == 2'd1: seg_d = blank_t ? SEG_BLANK : {1'b1, hex2seg(t_q)};
      default:     seg_d = {1'b1, hex2seg(o_q)};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_SHOW;
      boot_q    <= 1'b1;
      addr_q    <= '0;
      step_q    <= '0;
      refresh_q <= '0;
      h_q       <= '0;
      t_q       <= '0;
      o_q       <= '0;
      an        <= 4'hF;
      seg       <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      boot_q    <= 1'b0;
      refresh_q <= refresh_q + REF_ONE;
      an        <= an_d;
      seg       <= seg_d;
      // Step counter wraps to zero on terminal count, clearing itself.
      if (adv) begin
        step_q <= step_q + STEP_ONE;
        if (&step_q)
          addr_q <= addr_q + 4'd1;
      end
      if (conv_done)
        {h_q, t_q, o_q} <= conv_bcd;
    end
  end

endmodule
